riscv_fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the riscv_processor core. It issues sequential word fetches to an instruction memory with variable latency, over a valid/ready request channel and an in-order response channel. Fetched instructions are buffered in a prefetch FIFO and handed to decode over a valid/ready handshake. Branch/jump redirects flush the FIFO and squash all in-flight fetches.

---
 rtl/riscv_fetch_queue.sv | 128 ++++++++++++
 tb/tb_riscv_fetch_queue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_queue.sv
// Instruction-fetch front end: sequential word fetches limited by FIFO credit,
// in-order responses buffered for decode, redirects flush and squash in-flight fetches.
module riscv_fetch_queue #(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     ILEN            = 32,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int unsigned     FIFO_DEPTH      = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 fetch_enable,
    input  logic                                 redirect_valid,
    input  logic [XLEN-1:0]                      redirect_target,
    output logic                                 imem_req_valid,
    input  logic                                 imem_req_ready,
    output logic [XLEN-1:0]                      imem_req_addr,
    input  logic                                 imem_rsp_valid,
    input  logic [ILEN-1:0]                      imem_rsp_data,
    output logic                                 inst_valid,
    input  logic                                 inst_ready,
    output logic [ILEN-1:0]                      inst_data,
    output logic [XLEN-1:0]                      inst_pc,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] fetch_pc, rsp_pc, target_pc;
    logic [ILEN-1:0] data_mem [FIFO_DEPTH];
    logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic [OW-1:0]   outstanding, discard;
    logic [31:0]     credits_used;
    logic            req_fire, push, pop;
    logic            unused_target_bits;

    assign target_pc          = {redirect_target[XLEN-1:2], 2'b00};
    assign unused_target_bits = ^redirect_target[1:0];

    // Every in-flight request that is not going to be discarded owns a FIFO slot.
    always_comb begin
        state_next     = state;
        imem_req_valid = 1'b0;
        credits_used   = 32'(count) + 32'(outstanding) - 32'(discard);
        case (state)
            IDLE: begin
                if (fetch_enable) state_next = RUN;
            end
            RUN: begin
                if (!fetch_enable) state_next = IDLE;
                imem_req_valid = !redirect_valid
                              && (32'(outstanding) < MAX_OUTSTANDING)
                              && (credits_used < FIFO_DEPTH);
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_fire          = imem_req_valid && imem_req_ready;
    assign push              = imem_rsp_valid && !redirect_valid && (discard == '0);
    assign pop               = inst_valid && inst_ready && !redirect_valid;
    assign inst_valid        = (count != '0);
    assign inst_data         = data_mem[rd_ptr];
    assign inst_pc           = pc_mem[rd_ptr];
    assign imem_req_addr     = fetch_pc;
    assign outstanding_count = outstanding;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // On redirect every request still in flight after this cycle becomes stale.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= target_pc;
            rsp_pc      <= target_pc;
            outstanding <= outstanding - OW'(imem_rsp_valid);
            discard     <= outstanding - OW'(imem_rsp_valid);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
            if (push)     rsp_pc   <= rsp_pc + XLEN'(4);
            outstanding <= outstanding + OW'(req_fire) - OW'(imem_rsp_valid);
            if (imem_rsp_valid && (discard != '0)) discard <= discard - OW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (push) begin
            data_mem[wr_ptr] <= imem_rsp_data;
            pc_mem[wr_ptr]   <= rsp_pc;
        end
    end

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Directed bench for riscv_fetch_queue: in-order variable-latency memory model,
// request/pop logs, hand-computed expected addresses and PCs.
module tb_riscv_fetch_queue;

    localparam int FIFO_DEPTH = 4;
    localparam int MAX_OUT    = 2;

    logic        clk;
    logic        reset;
    logic        fetch_enable;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [1:0]  outstanding_count;

    riscv_fetch_queue dut (
        .clk               (clk),
        .reset             (reset),
        .fetch_enable      (fetch_enable),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_req_addr     (imem_req_addr),
        .imem_rsp_valid    (imem_rsp_valid),
        .imem_rsp_data     (imem_rsp_data),
        .inst_valid        (inst_valid),
        .inst_ready        (inst_ready),
        .inst_data         (inst_data),
        .inst_pc           (inst_pc),
        .outstanding_count (outstanding_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] req_log[$];
    logic [31:0] pc_log[$];
    logic [31:0] data_log[$];
    int          cyc;
    int          lat;
    int          viol;
    int          n_checks;
    int          n_fail;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hBAD0_BAD0;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One clock cycle: memory answers, outputs are logged mid-cycle, then the edge.
    task automatic step();
        mreq_t m;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(m.addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
        if (imem_rsp_valid && !redirect_valid && dut.discard == 0 && dut.count == FIFO_DEPTH) viol++;
        if (outstanding_count > MAX_OUT) viol++;
        if (imem_req_valid && imem_req_ready) begin
            req_log.push_back(imem_req_addr);
            m.addr = imem_req_addr;
            m.due  = cyc + lat;
            mq.push_back(m);
        end
        if (inst_valid && inst_ready && !redirect_valid) begin
            pc_log.push_back(inst_pc);
            data_log.push_back(inst_data);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset          = 1'b0;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        mq.delete();
        req_log.delete();
        pc_log.delete();
        data_log.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        viol            = 0;
        cyc             = 0;
        lat             = 1;
        fetch_enable    = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        imem_req_ready  = 1'b1;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = '0;
        inst_ready      = 1'b1;
        reset           = 1'b0;

        // Reset values while reset is held
        @(negedge clk);
        check_eq("rst_req_valid", imem_req_valid, 0);
        check_eq("rst_req_addr", imem_req_addr, 32'h0);
        check_eq("rst_inst_valid", inst_valid, 0);
        check_eq("rst_inst_data", inst_data, 32'h0);
        check_eq("rst_inst_pc", inst_pc, 32'h0);
        check_eq("rst_outstanding", outstanding_count, 0);

        // Streaming at one instruction per cycle
        do_reset();
        check_eq("t1_idle_no_req", imem_req_valid, 0);
        step();
        check_eq("t1_first_req_valid", imem_req_valid, 1);
        check_eq("t1_first_req_addr", imem_req_addr, 32'h0);
        steps(11);
        check_eq("t1_req0", q_at(req_log, 0), 32'h0);
        check_eq("t1_req1", q_at(req_log, 1), 32'h4);
        check_eq("t1_req5", q_at(req_log, 5), 32'h14);
        check_eq("t1_req_count", req_log.size(), 11);
        check_eq("t1_pop_count", pc_log.size(), 9);
        check_eq("t1_pc0", q_at(pc_log, 0), 32'h0);
        check_eq("t1_data0", q_at(data_log, 0), mem_word(32'h0));
        check_eq("t1_pc8", q_at(pc_log, 8), 32'h20);
        check_eq("t1_data8", q_at(data_log, 8), mem_word(32'h20));

        // Decode stalled: credit stops fetch at FIFO depth
        inst_ready = 1'b0;
        do_reset();
        steps(10);
        check_eq("t2_req_count", req_log.size(), 4);
        check_eq("t2_req_valid_low", imem_req_valid, 0);
        check_eq("t2_head_valid", inst_valid, 1);
        check_eq("t2_head_pc", inst_pc, 32'h0);
        check_eq("t2_head_data", inst_data, mem_word(32'h0));
        inst_ready = 1'b1;
        steps(6);
        check_eq("t2_resume_addr", q_at(req_log, 4), 32'h10);
        check_eq("t2_pop_pc0", q_at(pc_log, 0), 32'h0);
        check_eq("t2_pop_pc1", q_at(pc_log, 1), 32'h4);

        // Redirect with two requests in flight, latency 3
        lat = 3;
        do_reset();
        steps(7);
        check_eq("t3_inflight", outstanding_count, 2);
        check_eq("t3_req_count", req_log.size(), 4);
        check_eq("t3_last_req", q_at(req_log, 3), 32'hC);
        redirect_valid  = 1'b1;
        redirect_target = 32'h103;
        step();
        redirect_valid = 1'b0;
        check_eq("t3_flushed", inst_valid, 0);
        check_eq("t3_new_addr", imem_req_addr, 32'h100);
        check_eq("t3_stale_inflight", outstanding_count, 2);
        steps(8);
        check_eq("t3_first_new_req", q_at(req_log, 4), 32'h100);
        check_eq("t3_pop_count", pc_log.size(), 4);
        check_eq("t3_new_pc", q_at(pc_log, 2), 32'h100);
        check_eq("t3_new_data", q_at(data_log, 2), mem_word(32'h100));

        // Redirect coinciding with a response and a pop
        lat        = 2;
        inst_ready = 1'b0;
        do_reset();
        steps(6);
        check_eq("t4_head_valid", inst_valid, 1);
        check_eq("t4_head_pc", inst_pc, 32'h0);
        check_eq("t4_inflight", outstanding_count, 2);
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        inst_ready      = 1'b1;
        step();
        redirect_valid = 1'b0;
        check_eq("t4_flushed", inst_valid, 0);
        check_eq("t4_outstanding", outstanding_count, 1);
        check_eq("t4_discard", dut.discard, 1);
        check_eq("t4_new_addr", imem_req_addr, 32'h200);
        steps(6);
        check_eq("t4_pop_pc0", q_at(pc_log, 0), 32'h200);
        check_eq("t4_pop_data0", q_at(data_log, 0), mem_word(32'h200));
        check_eq("t4_pop_pc1", q_at(pc_log, 1), 32'h204);

        // fetch_enable dropped with two in flight
        lat = 3;
        do_reset();
        steps(3);
        fetch_enable = 1'b0;
        steps(8);
        check_eq("t5_req_count", req_log.size(), 2);
        check_eq("t5_pop_count", pc_log.size(), 2);
        check_eq("t5_pop_pc1", q_at(pc_log, 1), 32'h4);
        check_eq("t5_no_req", imem_req_valid, 0);
        check_eq("t5_drained", outstanding_count, 0);
        fetch_enable = 1'b1;
        steps(8);
        check_eq("t5_resume_addr", q_at(req_log, 2), 32'h8);
        check_eq("t5_resume_pc", q_at(pc_log, 2), 32'h8);

        // Back-to-back redirects, last one wraps the address space
        lat = 1;
        do_reset();
        steps(3);
        redirect_valid  = 1'b1;
        redirect_target = 32'h300;
        step();
        redirect_target = 32'hFFFF_FFFE;
        step();
        redirect_valid = 1'b0;
        check_eq("t6_req_count", req_log.size(), 2);
        check_eq("t6_no_pop", pc_log.size(), 0);
        steps(6);
        check_eq("t6_req_top", q_at(req_log, 2), 32'hFFFF_FFFC);
        check_eq("t6_req_wrap", q_at(req_log, 3), 32'h0);
        check_eq("t6_pc_top", q_at(pc_log, 0), 32'hFFFF_FFFC);
        check_eq("t6_pc_wrap", q_at(pc_log, 1), 32'h0);
        check_eq("t6_data_wrap", q_at(data_log, 1), mem_word(32'h0));

        check_eq("invariants", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
